// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU controller: FSM states, instruction classes,
// opcode/op fields, ALU ops, write-back select and memory commands.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE, S_WRITE_IMM,
    S_ADDR, S_LD_ADDR, S_MEM_RD, S_WR_MEM, S_PASS, S_MEM_WR, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_MOV_IMM, CLS_MOV_REG, CLS_ALU, CLS_CMP, CLS_MVN,
    CLS_LDR, CLS_STR, CLS_HALT
  } instr_class_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] WB_C     = 2'b00;
  localparam logic [1:0] WB_PC    = 2'b01;
  localparam logic [1:0] WB_IMM   = 2'b10;
  localparam logic [1:0] WB_MDATA = 2'b11;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational instruction decoder: splits the IR into register fields and
// immediates and classifies the instruction. Opcode 111 decodes to HALT only
// when CPU_CTRL_HALT_EN is defined.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0]  ir,
  output logic [2:0]   rn,
  output logic [2:0]   rd,
  output logic [2:0]   rm,
  output logic [1:0]   sh,
  output logic [15:0]  sximm5,
  output logic [15:0]  sximm8,
  output instr_class_t cls
);

  logic [2:0] opcode;
  logic [1:0] op;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm5 = sext5(ir[4:0]);
  assign sximm8 = sext8(ir[7:0]);

  always_comb begin
    cls = CLS_NONE;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
        else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  cls = CLS_ALU;
          OP_CMP:  cls = CLS_CMP;
          OP_AND:  cls = CLS_ALU;
          default: cls = CLS_MVN;
        endcase
      end
      OPC_LDR: if (op == 2'b00) cls = CLS_LDR;
      OPC_STR: if (op == 2'b00) cls = CLS_STR;
`ifdef CPU_CTRL_HALT_EN
      OPC_HALT: cls = CLS_HALT;
`endif
      default: cls = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus multi-cycle Moore FSM driving the register/ALU
// datapath and LDR/STR memory commands. CPU_CTRL_HALT_EN enables the HALT state.
module cpu_controller
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  w_addr,
  output logic        w_en,
  output logic [2:0]  r_addr,
  output logic [1:0]  wb_sel,
  output logic        en_A,
  output logic        en_B,
  output logic        en_C,
  output logic        en_status,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  shift_op,
  output logic [1:0]  ALU_op,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        load_addr,
  output mem_cmd_t    mem_cmd,
  output state_t      dbg_state
);

  state_t       state, state_next;
  logic [15:0]  ir;
  logic [2:0]   rn, rd, rm;
  logic [1:0]   sh;
  instr_class_t cls;

  instr_decoder u_dec (
    .ir     (ir),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  assign dbg_state = state;

  // load and s are only honoured in WAIT; a same-cycle load feeds DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == S_WAIT && load) ir <= in;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_WAIT:   if (s) state_next = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_MOV_IMM:                      state_next = S_WRITE_IMM;
          CLS_MOV_REG, CLS_MVN:             state_next = S_GET_B;
          CLS_ALU, CLS_CMP, CLS_LDR, CLS_STR: state_next = S_GET_A;
          CLS_HALT:                         state_next = S_HALT;
          default:                          state_next = S_WAIT;
        endcase
      end
      S_GET_A:     state_next = (cls == CLS_LDR || cls == CLS_STR) ? S_ADDR : S_GET_B;
      S_GET_B:     state_next = (cls == CLS_STR) ? S_PASS : S_EXEC;
      S_EXEC:      state_next = (cls == CLS_CMP) ? S_WAIT : S_WRITE;
      S_WRITE:     state_next = S_WAIT;
      S_WRITE_IMM: state_next = S_WAIT;
      S_ADDR:      state_next = S_LD_ADDR;
      S_LD_ADDR:   state_next = (cls == CLS_LDR) ? S_MEM_RD : S_GET_B;
      S_MEM_RD:    state_next = S_WR_MEM;
      S_WR_MEM:    state_next = S_WAIT;
      S_PASS:      state_next = S_MEM_WR;
      S_MEM_WR:    state_next = S_WAIT;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_WAIT;
    endcase
  end

  // Outputs are forced quiet while reset is high so an aborted instruction
  // cannot write the regfile or status in its final cycle.
  always_comb begin
    w         = 1'b0;
    w_addr    = 3'd0;
    w_en      = 1'b0;
    r_addr    = 3'd0;
    wb_sel    = WB_C;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    shift_op  = 2'b00;
    ALU_op    = ALU_ADD;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    if (reset) begin
      w = 1'b1;
    end else begin
      case (state)
        S_WAIT: w = 1'b1;
        S_GET_A: begin
          r_addr = rn;
          en_A   = 1'b1;
        end
        S_GET_B: begin
          r_addr = (cls == CLS_STR) ? rd : rm;
          en_B   = 1'b1;
        end
        S_EXEC: begin
          sel_A     = (cls == CLS_MOV_REG);
          shift_op  = sh;
          ALU_op    = (cls == CLS_MOV_REG) ? ALU_ADD : ir[12:11];
          en_C      = (cls != CLS_CMP);
          en_status = (cls == CLS_CMP);
        end
        S_WRITE: begin
          wb_sel = WB_C;
          w_addr = rd;
          w_en   = 1'b1;
        end
        S_WRITE_IMM: begin
          wb_sel = WB_IMM;
          w_addr = rn;
          w_en   = 1'b1;
        end
        S_ADDR: begin
          sel_B = 1'b1;
          en_C  = 1'b1;
        end
        S_LD_ADDR: load_addr = 1'b1;
        S_MEM_RD:  mem_cmd = MEM_READ;
        S_WR_MEM: begin
          mem_cmd = MEM_READ;
          wb_sel  = WB_MDATA;
          w_addr  = rd;
          w_en    = 1'b1;
        end
        S_PASS: begin
          sel_A = 1'b1;
          en_C  = 1'b1;
        end
        S_MEM_WR: mem_cmd = MEM_WRITE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller; inputs and samples are
// taken on the falling clock edge. Honors CPU_CTRL_HALT_EN for opcode 111.
module tb_cpu_controller;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, load_addr;
  logic [2:0]  w_addr, r_addr;
  logic [1:0]  wb_sel, shift_op, ALU_op;
  logic [15:0] sximm8, sximm5;
  mem_cmd_t    mem_cmd;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  cpu_controller dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .w_addr(w_addr), .w_en(w_en), .r_addr(r_addr), .wb_sel(wb_sel),
    .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
    .sel_A(sel_A), .sel_B(sel_B), .shift_op(shift_op), .ALU_op(ALU_op),
    .sximm8(sximm8), .sximm5(sximm5), .load_addr(load_addr),
    .mem_cmd(mem_cmd), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Called at a falling edge while in WAIT; returns at the falling edge in DECODE.
  task automatic start(input logic [15:0] instr, input logic do_load);
    in = instr; load = do_load; s = 1'b1;
    step();
    load = 1'b0; s = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
    step(); step();
    checks++;
    if ({w, w_en, en_A, en_B, en_C, en_status, load_addr} !== 7'b1000000 || mem_cmd !== MEM_NONE) begin
      errors++; $display("FAIL reset_outputs: w/w_en/enA/enB/enC/enS/ld=%b mem=%0d, need 1000000 mem=0",
        {w, w_en, en_A, en_B, en_C, en_status, load_addr}, mem_cmd);
    end
    reset = 1'b0;
    step();
    checks++;
    if (dbg_state !== S_WAIT || w !== 1'b1 || sximm8 !== 16'h0000) begin
      errors++; $display("FAIL reset_state: state=%0d w=%b sximm8=%h, need WAIT w=1 sximm8=0000",
        dbg_state, w, sximm8);
    end
  endtask

  task automatic test_mov_imm();
    start(16'hD0FE, 1'b1);  // MOV R0,#-2
    checks++;
    if (w !== 1'b0 || w_en !== 1'b0) begin
      errors++; $display("FAIL mov_imm_decode: w=%b w_en=%b, need 0 0", w, w_en);
    end
    step();
    checks++;
    if (w_en !== 1'b1 || w_addr !== 3'd0 || wb_sel !== 2'b10 || sximm8 !== 16'hFFFE) begin
      errors++; $display("FAIL mov_imm_write: w_en=%b w_addr=%0d wb_sel=%b sximm8=%h, need 1 0 10 FFFE",
        w_en, w_addr, wb_sel, sximm8);
    end
    step();
    checks++;
    if (w !== 1'b1 || w_en !== 1'b0) begin
      errors++; $display("FAIL mov_imm_done: w=%b w_en=%b, need 1 0", w, w_en);
    end
  endtask

  task automatic test_add();
    start(16'hA148, 1'b1);  // ADD R2,R1,R0 LSL#1
    step();
    checks++;
    if (r_addr !== 3'd1 || en_A !== 1'b1 || en_B !== 1'b0) begin
      errors++; $display("FAIL add_get_a: r_addr=%0d en_A=%b en_B=%b, need 1 1 0", r_addr, en_A, en_B);
    end
    step();
    checks++;
    if (r_addr !== 3'd0 || en_B !== 1'b1 || en_A !== 1'b0) begin
      errors++; $display("FAIL add_get_b: r_addr=%0d en_B=%b en_A=%b, need 0 1 0", r_addr, en_B, en_A);
    end
    step();
    checks++;
    if (shift_op !== 2'b01 || en_C !== 1'b1 || ALU_op !== 2'b00 || sel_A !== 1'b0 || sel_B !== 1'b0 || en_status !== 1'b0) begin
      errors++; $display("FAIL add_exec: shift=%b en_C=%b alu=%b selA=%b selB=%b enS=%b, need 01 1 00 0 0 0",
        shift_op, en_C, ALU_op, sel_A, sel_B, en_status);
    end
    step();
    checks++;
    if (w_en !== 1'b1 || w_addr !== 3'd2 || wb_sel !== 2'b00 || w !== 1'b0) begin
      errors++; $display("FAIL add_write: w_en=%b w_addr=%0d wb_sel=%b w=%b, need 1 2 00 0", w_en, w_addr, wb_sel, w);
    end
    step();
    checks++;
    if (w !== 1'b1 || w_en !== 1'b0) begin
      errors++; $display("FAIL add_done: w=%b w_en=%b, need 1 0", w, w_en);
    end
  endtask

  task automatic test_cmp();
    int n_status = 0;
    int n_wen = 0;
    int n_enc = 0;
    start(16'hA900, 1'b1);  // CMP R1,R0
    for (int k = 0; k < 4; k++) begin
      n_status += int'(en_status);
      n_wen += int'(w_en);
      n_enc += int'(en_C);
      step();
    end
    checks++;
    if (n_status != 1 || n_wen != 0 || n_enc != 0) begin
      errors++; $display("FAIL cmp_enables: en_status cycles=%0d w_en cycles=%0d en_C cycles=%0d, need 1 0 0",
        n_status, n_wen, n_enc);
    end
    checks++;
    if (w !== 1'b1) begin
      errors++; $display("FAIL cmp_latency: w=%b after 4 cycles, need 1", w);
    end
  endtask

  task automatic test_ldr();
    start(16'h617F, 1'b1);  // LDR R3,[R1,#-1]
    checks++;
    if (sximm5 !== 16'hFFFF) begin
      errors++; $display("FAIL ldr_sximm5: got %h, need FFFF", sximm5);
    end
    step();
    checks++;
    if (r_addr !== 3'd1 || en_A !== 1'b1) begin
      errors++; $display("FAIL ldr_get_a: r_addr=%0d en_A=%b, need 1 1", r_addr, en_A);
    end
    step();
    checks++;
    if (sel_B !== 1'b1 || en_C !== 1'b1 || ALU_op !== 2'b00 || sel_A !== 1'b0) begin
      errors++; $display("FAIL ldr_addr: selB=%b en_C=%b alu=%b selA=%b, need 1 1 00 0", sel_B, en_C, ALU_op, sel_A);
    end
    step();
    checks++;
    if (load_addr !== 1'b1 || mem_cmd !== MEM_NONE) begin
      errors++; $display("FAIL ldr_ld_addr: load_addr=%b mem=%0d, need 1 0", load_addr, mem_cmd);
    end
    step();
    checks++;
    if (mem_cmd !== MEM_READ || w_en !== 1'b0 || load_addr !== 1'b0) begin
      errors++; $display("FAIL ldr_mem_rd: mem=%0d w_en=%b load_addr=%b, need 1 0 0", mem_cmd, w_en, load_addr);
    end
    step();
    checks++;
    if (mem_cmd !== MEM_READ || wb_sel !== 2'b11 || w_en !== 1'b1 || w_addr !== 3'd3) begin
      errors++; $display("FAIL ldr_wr_mem: mem=%0d wb_sel=%b w_en=%b w_addr=%0d, need 1 11 1 3",
        mem_cmd, wb_sel, w_en, w_addr);
    end
    step();
    checks++;
    if (w !== 1'b1 || mem_cmd !== MEM_NONE) begin
      errors++; $display("FAIL ldr_done: w=%b mem=%0d, need 1 0", w, mem_cmd);
    end
  endtask

  task automatic test_str();
    int n_wen = 0;
    int n_wr = 0;
    start(16'h8164, 1'b1);  // STR R3,[R1,#4]
    checks++;
    if (sximm5 !== 16'h0004) begin
      errors++; $display("FAIL str_sximm5: got %h, need 0004", sximm5);
    end
    for (int k = 0; k < 7; k++) begin
      n_wen += int'(w_en);
      n_wr += int'(mem_cmd == MEM_WRITE);
      if (k == 4) begin
        checks++;
        if (r_addr !== 3'd3 || en_B !== 1'b1) begin
          errors++; $display("FAIL str_get_b: r_addr=%0d en_B=%b, need 3 1", r_addr, en_B);
        end
      end
      if (k == 5) begin
        checks++;
        if (sel_A !== 1'b1 || en_C !== 1'b1 || shift_op !== 2'b00 || ALU_op !== 2'b00 || mem_cmd !== MEM_NONE) begin
          errors++; $display("FAIL str_pass: selA=%b en_C=%b shift=%b alu=%b mem=%0d, need 1 1 00 00 0",
            sel_A, en_C, shift_op, ALU_op, mem_cmd);
        end
      end
      if (k == 6) begin
        checks++;
        if (mem_cmd !== MEM_WRITE) begin
          errors++; $display("FAIL str_mem_wr: mem=%0d, need 2", mem_cmd);
        end
      end
      step();
    end
    checks++;
    if (n_wen != 0 || n_wr != 1 || w !== 1'b1) begin
      errors++; $display("FAIL str_summary: w_en cycles=%0d write cycles=%0d w=%b, need 0 1 1", n_wen, n_wr, w);
    end
  endtask

  task automatic test_mvn_mov_reg();
    start(16'hB822, 1'b1);  // MVN R1,R2
    step();
    checks++;
    if (r_addr !== 3'd2 || en_B !== 1'b1 || en_A !== 1'b0) begin
      errors++; $display("FAIL mvn_get_b: r_addr=%0d en_B=%b en_A=%b, need 2 1 0", r_addr, en_B, en_A);
    end
    step();
    checks++;
    if (ALU_op !== 2'b11 || en_C !== 1'b1 || sel_A !== 1'b0) begin
      errors++; $display("FAIL mvn_exec: alu=%b en_C=%b selA=%b, need 11 1 0", ALU_op, en_C, sel_A);
    end
    step();
    checks++;
    if (w_en !== 1'b1 || w_addr !== 3'd1) begin
      errors++; $display("FAIL mvn_write: w_en=%b w_addr=%0d, need 1 1", w_en, w_addr);
    end
    step();
    start(16'hC095, 1'b1);  // MOV R4,R5 ASR-style sh=10
    step();
    checks++;
    if (r_addr !== 3'd5 || en_B !== 1'b1) begin
      errors++; $display("FAIL movr_get_b: r_addr=%0d en_B=%b, need 5 1", r_addr, en_B);
    end
    step();
    checks++;
    if (sel_A !== 1'b1 || ALU_op !== 2'b00 || shift_op !== 2'b10 || en_C !== 1'b1) begin
      errors++; $display("FAIL movr_exec: selA=%b alu=%b shift=%b en_C=%b, need 1 00 10 1", sel_A, ALU_op, shift_op, en_C);
    end
    step();
    checks++;
    if (w_en !== 1'b1 || w_addr !== 3'd4 || wb_sel !== 2'b00) begin
      errors++; $display("FAIL movr_write: w_en=%b w_addr=%0d wb_sel=%b, need 1 4 00", w_en, w_addr, wb_sel);
    end
    step();
  endtask

  task automatic test_latency();
    logic [15:0] instr_tab [9] = '{16'hA148, 16'hB148, 16'hB822, 16'hC095, 16'hA900,
                                   16'hD0FE, 16'h617F, 16'h8164, 16'h0000};
    int lat_tab [9] = '{5, 5, 4, 4, 4, 2, 6, 7, 1};
    for (int i = 0; i < 9; i++) begin
      int n = 0;
      start(instr_tab[i], 1'b1);
      while (w !== 1'b1 && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (n != lat_tab[i]) begin
        errors++; $display("FAIL latency_%h: got %0d cycles, need %0d", instr_tab[i], n, lat_tab[i]);
      end
    end
  endtask

  task automatic test_unlisted();
    logic [15:0] bad_tab [3] = '{16'hC800, 16'h6800, 16'h8800};
    for (int i = 0; i < 3; i++) begin
      start(bad_tab[i], 1'b1);
      checks++;
      if ({w_en, en_A, en_B, en_C, en_status} !== 5'b0) begin
        errors++; $display("FAIL unlisted_%h_decode: enables=%b, need 00000", bad_tab[i],
          {w_en, en_A, en_B, en_C, en_status});
      end
      step();
      checks++;
      if (w !== 1'b1 || dbg_state !== S_WAIT) begin
        errors++; $display("FAIL unlisted_%h: w=%b state=%0d, need 1 WAIT", bad_tab[i], w, dbg_state);
      end
    end
    start(16'hE000, 1'b1);
    step(); step(); step();
`ifdef CPU_CTRL_HALT_EN
    checks++;
    if (w !== 1'b0 || dbg_state !== S_HALT || {w_en, en_A, en_B, en_C, en_status} !== 5'b0) begin
      errors++; $display("FAIL halt_hold: w=%b state=%0d, need 0 HALT", w, dbg_state);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
`endif
    checks++;
    if (w !== 1'b1 || dbg_state !== S_WAIT) begin
      errors++; $display("FAIL opcode111_end: w=%b state=%0d, need 1 WAIT", w, dbg_state);
    end
  endtask

  task automatic test_reset_mid();
    start(16'hA148, 1'b1);
    step(); step(); step();
    checks++;
    if (dbg_state !== S_EXEC || en_C !== 1'b1) begin
      errors++; $display("FAIL rmid_in_exec: state=%0d en_C=%b, need EXEC 1", dbg_state, en_C);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (en_C !== 1'b0 || w_en !== 1'b0) begin
      errors++; $display("FAIL rmid_gated: en_C=%b w_en=%b, need 0 0", en_C, w_en);
    end
    step();
    reset = 1'b0;
    checks++;
    if (dbg_state !== S_WAIT || w !== 1'b1 || w_en !== 1'b0) begin
      errors++; $display("FAIL rmid_abort: state=%0d w=%b w_en=%b, need WAIT 1 0", dbg_state, w, w_en);
    end
    step();
    checks++;
    if (w_en !== 1'b0 || w !== 1'b1) begin
      errors++; $display("FAIL rmid_after: w_en=%b w=%b, need 0 1", w_en, w);
    end
  endtask

  task automatic test_ignore_inputs();
    int n = 0;
    start(16'hA900, 1'b1);  // CMP; mid-instruction load/s must not touch IR
    step();
    in = 16'hD0FE; load = 1'b1; s = 1'b1;
    step();
    load = 1'b0; s = 1'b0;
    step();
    checks++;
    if (en_status !== 1'b1 || sximm8 !== 16'h0000) begin
      errors++; $display("FAIL ignore_exec: en_status=%b sximm8=%h, need 1 0000", en_status, sximm8);
    end
    step();
    checks++;
    if (w !== 1'b1) begin
      errors++; $display("FAIL ignore_latency: w=%b, need 1", w);
    end
    // s alone re-runs the retained CMP despite a different word on in
    start(16'hD0FE, 1'b0);
    checks++;
    if (sximm8 !== 16'h0000) begin
      errors++; $display("FAIL ignore_ir_kept: sximm8=%h, need 0000", sximm8);
    end
    while (w !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL ignore_rerun: latency=%0d, need 4", n);
    end
  endtask

  task automatic test_back_to_back();
    // load alone in WAIT latches without starting
    in = 16'hD3FE; load = 1'b1; s = 1'b0;
    step();
    load = 1'b0;
    checks++;
    if (dbg_state !== S_WAIT || sximm8 !== 16'hFFFE) begin
      errors++; $display("FAIL b2b_load_only: state=%0d sximm8=%h, need WAIT FFFE", dbg_state, sximm8);
    end
    start(16'h0000, 1'b0);
    step();
    checks++;
    if (w_en !== 1'b1 || w_addr !== 3'd3 || wb_sel !== 2'b10) begin
      errors++; $display("FAIL b2b_mov_r3: w_en=%b w_addr=%0d wb_sel=%b, need 1 3 10", w_en, w_addr, wb_sel);
    end
    step();
    start(16'hD57F, 1'b1);  // MOV R5,#127 started the cycle w returns
    step();
    checks++;
    if (w_en !== 1'b1 || w_addr !== 3'd5 || sximm8 !== 16'h007F) begin
      errors++; $display("FAIL b2b_mov_r5: w_en=%b w_addr=%0d sximm8=%h, need 1 5 007F", w_en, w_addr, sximm8);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_ldr();
    test_str();
    test_mvn_mov_reg();
    test_latency();
    test_unlisted();
    test_reset_mid();
    test_ignore_inputs();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
